muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - bit-serial 8x8 multiply / 16/8 restoring divide engine (option: MULDIV_INSTANT_EN)
module muldiv_unit #(
   parameter int MUL_STEPS = 8,
   parameter int DIV_STEPS = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cpu_en,
   input  logic [7:0]  mpya,
   input  logic        mpyb_write,
   input  logic [7:0]  mpyb_wdata,
   input  logic [15:0] dividend,
   input  logic        divb_write,
   input  logic [7:0]  divb_wdata,
   output logic [15:0] rddiv,
   output logic [15:0] rdmpy,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic [7:0]  a_sh_q, a_sh_d;
   logic [15:0] b_sh_q, b_sh_d;
   // Remainder is kept 16 bits wide so that a zero divisor returns the whole dividend.
   logic [15:0] rem_q, rem_d;
   logic [15:0] quo_q, quo_d;
   logic [7:0]  dvs_q, dvs_d;
   logic [15:0] rddiv_q, rddiv_d;
   logic [15:0] rdmpy_q, rdmpy_d;

   logic        start_mul;
   logic        start_div;
   logic [16:0] rem_shift;
   logic [16:0] rem_sub;
   logic        rem_ge;

   // Multiply trigger has priority when both trigger writes land on the same enabled edge.
   assign start_mul = cpu_en & mpyb_write;
   assign start_div = cpu_en & divb_write & ~mpyb_write;

   // One restoring-divide step: shift remainder:quotient left, trial-subtract the divisor.
   assign rem_shift = {rem_q, quo_q[15]};
   assign rem_sub   = rem_shift - {9'd0, dvs_q};
   assign rem_ge    = (rem_shift >= {9'd0, dvs_q});

   // Next-state and datapath update; starts abort any running operation.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      rddiv_d = rddiv_q;
      rdmpy_d = rdmpy_q;

      if (start_mul) begin
`ifdef MULDIV_INSTANT_EN
         rddiv_d = {8'h00, mpyb_wdata};
         rdmpy_d = {8'h00, mpya} * {8'h00, mpyb_wdata};
         state_d = IDLE;
         count_d = 5'd0;
`else
         rddiv_d = {8'h00, mpyb_wdata};
         rdmpy_d = 16'h0000;
         a_sh_d  = mpya;
         b_sh_d  = {8'h00, mpyb_wdata};
         count_d = 5'd0;
         state_d = MUL;
`endif
      end else if (start_div) begin
`ifdef MULDIV_INSTANT_EN
         if (divb_wdata == 8'h00) begin
            rddiv_d = 16'hFFFF;
            rdmpy_d = dividend;
         end else begin
            rddiv_d = dividend / {8'h00, divb_wdata};
            rdmpy_d = dividend % {8'h00, divb_wdata};
         end
         state_d = IDLE;
         count_d = 5'd0;
`else
         rem_d   = 16'h0000;
         quo_d   = dividend;
         dvs_d   = divb_wdata;
         count_d = 5'd0;
         state_d = DIV;
`endif
      end else if (cpu_en) begin
         case (state_q)
            MUL: begin
               if (a_sh_q[0]) begin
                  rdmpy_d = rdmpy_q + b_sh_q;
               end
               a_sh_d  = {1'b0, a_sh_q[7:1]};
               b_sh_d  = {b_sh_q[14:0], 1'b0};
               count_d = count_q + 5'd1;
               if (count_q == 5'(MUL_STEPS - 1)) begin
                  state_d = IDLE;
               end
            end
            DIV: begin
               quo_d   = {quo_q[14:0], rem_ge};
               rem_d   = rem_ge ? rem_sub[15:0] : rem_shift[15:0];
               count_d = count_q + 5'd1;
               if (count_q == 5'(DIV_STEPS - 1)) begin
                  rddiv_d = {quo_q[14:0], rem_ge};
                  rdmpy_d = rem_ge ? rem_sub[15:0] : rem_shift[15:0];
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers, cleared immediately by reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         count_q <= 5'd0;
         a_sh_q  <= 8'h00;
         b_sh_q  <= 16'h0000;
         rem_q   <= 16'h0000;
         quo_q   <= 16'h0000;
         dvs_q   <= 8'h00;
         rddiv_q <= 16'h0000;
         rdmpy_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         rddiv_q <= rddiv_d;
         rdmpy_q <= rdmpy_d;
      end
   end

   assign rddiv = rddiv_q;
   assign rdmpy = rdmpy_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cpu_en = 1'b0;
   logic [7:0]  mpya = 8'h00;
   logic        mpyb_write = 1'b0;
   logic [7:0]  mpyb_wdata = 8'h00;
   logic [15:0] dividend = 16'h0000;
   logic        divb_write = 1'b0;
   logic [7:0]  divb_wdata = 8'h00;
   logic [15:0] rddiv;
   logic [15:0] rdmpy;
   logic        busy;

   int n_checks = 0;
   int n_fail = 0;

   muldiv_unit dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cpu_en     (cpu_en),
      .mpya       (mpya),
      .mpyb_write (mpyb_write),
      .mpyb_wdata (mpyb_wdata),
      .dividend   (dividend),
      .divb_write (divb_write),
      .divb_wdata (divb_wdata),
      .rddiv      (rddiv),
      .rdmpy      (rdmpy),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_mul;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] dvd;
      logic [15:0] exp_rddiv;
      logic [15:0] exp_rdmpy;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: results from plain arithmetic on the operands.
   task automatic model(input bit is_mul, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] dvd, output logic [15:0] q, output logic [15:0] r);
      int unsigned prod;
      if (is_mul) begin
         prod = int'(a) * int'(b);
         q = {8'h00, b};
         r = prod[15:0];
      end else if (b == 8'h00) begin
         q = 16'hFFFF;
         r = dvd;
      end else begin
         q = 16'(int'(dvd) / int'(b));
         r = 16'(int'(dvd) % int'(b));
      end
   endtask

   // en_mode: 0 = always enabled, 1 = alternating starting low, 2 = random with operand churn.
   task automatic run_op(input bit is_mul, input bit both, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] dvd, input int en_mode,
                         output int steps, output int edges);
      mpya = a;
      dividend = dvd;
      mpyb_wdata = b;
      divb_wdata = b;
      mpyb_write = is_mul;
      divb_write = !is_mul || both;
      cpu_en = 1'b1;
      tick();
      mpyb_write = 1'b0;
      divb_write = 1'b0;
      check("busy_after_start", busy, 1);
      steps = 0;
      edges = 0;
      while (busy && edges < 400) begin
         case (en_mode)
            0: cpu_en = 1'b1;
            1: cpu_en = edges[0];
            default: begin
               cpu_en = 1'($urandom_range(0, 1));
               if ($urandom_range(0, 3) == 0) begin
                  mpya = 8'($urandom);
                  dividend = 16'($urandom);
               end
            end
         endcase
         tick();
         edges++;
         if (cpu_en) steps++;
      end
      if (edges >= 400) check("op_timeout", 1, 0);
      cpu_en = 1'b1;
   endtask

   vec_t vecs[8];

   initial begin
      int steps, edges;
      logic [15:0] eq, er;
      bit seen_div;
      bit m;
      logic [7:0] ra, rb;
      logic [15:0] rd;

      vecs[0] = '{1'b1, 8'h12, 8'h34, 16'h0000, 16'h0034, 16'h03A8};
      vecs[1] = '{1'b1, 8'hFF, 8'hFF, 16'h0000, 16'h00FF, 16'hFE01};
      vecs[2] = '{1'b0, 8'h00, 8'd7,  16'd1000, 16'h008E, 16'h0006};
      vecs[3] = '{1'b0, 8'h00, 8'h00, 16'h1234, 16'hFFFF, 16'h1234};
      vecs[4] = '{1'b1, 8'h00, 8'hAB, 16'h0000, 16'h00AB, 16'h0000};
      vecs[5] = '{1'b0, 8'h00, 8'h01, 16'hFFFF, 16'hFFFF, 16'h0000};
      vecs[6] = '{1'b0, 8'h00, 8'hFF, 16'h00FF, 16'h0001, 16'h0000};
      vecs[7] = '{1'b0, 8'h00, 8'h10, 16'h0005, 16'h0000, 16'h0005};

      #2;
      check("reset_rddiv", rddiv, 16'h0000);
      check("reset_rdmpy", rdmpy, 16'h0000);
      check("reset_busy", busy, 0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].is_mul, 1'b0, vecs[i].a, vecs[i].b, vecs[i].dvd, 0, steps, edges);
         check($sformatf("vec%0d_steps", i), steps, vecs[i].is_mul ? 8 : 16);
         check($sformatf("vec%0d_rddiv", i), rddiv, vecs[i].exp_rddiv);
         check($sformatf("vec%0d_rdmpy", i), rdmpy, vecs[i].exp_rdmpy);
      end

      run_op(1'b1, 1'b0, 8'hFF, 8'hFF, 16'h0000, 1, steps, edges);
      check("alt_en_edges", edges, 16);
      check("alt_en_steps", steps, 8);
      check("alt_en_rdmpy", rdmpy, 16'hFE01);

      // Triggers with cpu_en low must be ignored.
      cpu_en = 1'b0;
      mpyb_write = 1'b1;
      mpyb_wdata = 8'h99;
      divb_write = 1'b1;
      tick();
      mpyb_write = 1'b0;
      divb_write = 1'b0;
      tick();
      check("gated_trigger_busy", busy, 0);
      check("gated_trigger_rddiv", rddiv, 16'h00FF);
      cpu_en = 1'b1;

      // Abort a divide with a multiply after 5 steps.
      dividend = 16'hFFFF;
      divb_wdata = 8'h03;
      divb_write = 1'b1;
      tick();
      divb_write = 1'b0;
      seen_div = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (rddiv == 16'h5555) seen_div = 1'b1;
      end
      check("abort_div_busy", busy, 1);
      mpya = 8'h10;
      mpyb_wdata = 8'h02;
      mpyb_write = 1'b1;
      tick();
      mpyb_write = 1'b0;
      steps = 0;
      while (busy && steps < 100) begin
         tick();
         steps++;
         if (rddiv == 16'h5555) seen_div = 1'b1;
      end
      check("abort_mul_steps", steps, 8);
      check("abort_rdmpy", rdmpy, 16'h0020);
      check("abort_rddiv", rddiv, 16'h0002);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rddiv == 16'h5555) seen_div = 1'b1;
      end
      check("abort_no_div_result", seen_div, 0);
      check("abort_hold_rdmpy", rdmpy, 16'h0020);

      // Same-edge triggers: the multiply wins.
      run_op(1'b1, 1'b1, 8'h0B, 8'h0D, 16'h4000, 0, steps, edges);
      check("both_steps", steps, 8);
      check("both_rdmpy", rdmpy, 16'h008F);
      check("both_rddiv", rddiv, 16'h000D);

      // Asynchronous reset between edges mid-multiply.
      mpya = 8'h12;
      mpyb_wdata = 8'h34;
      mpyb_write = 1'b1;
      tick();
      mpyb_write = 1'b0;
      tick();
      tick();
      tick();
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_rddiv", rddiv, 16'h0000);
      check("async_rst_rdmpy", rdmpy, 16'h0000);
      check("async_rst_busy", busy, 0);
      tick();
      reset_n = 1'b1;
      tick();
      run_op(1'b1, 1'b0, 8'h05, 8'h07, 16'h0000, 0, steps, edges);
      check("post_rst_steps", steps, 8);
      check("post_rst_rdmpy", rdmpy, 16'h0023);

      // Randomized operations with random enable and operand churn.
      for (int i = 0; i < 40; i++) begin
         m = 1'($urandom_range(0, 1));
         ra = 8'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         rd = 16'($urandom);
         model(m, ra, rb, rd, eq, er);
         run_op(m, 1'b0, ra, rb, rd, 2, steps, edges);
         check($sformatf("rnd%0d_steps", i), steps, m ? 8 : 16);
         check($sformatf("rnd%0d_rddiv", i), rddiv, eq);
         check($sformatf("rnd%0d_rdmpy", i), rdmpy, er);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
